// File: rtl/i2c_spi_bridge.sv
// ---------------------------------------------------------------------------
// i2c_spi_bridge
//
// I2C slave that forwards every written data byte to a mode-0 SPI master.
// While a byte is shifted out on MOSI, the reply on MISO is captured into
// rx_reg_r. A later I2C read returns that captured byte, repeated for as
// long as the I2C master keeps acknowledging.
//
// Parameters
//   I2C_ADDR  7-bit slave address.
//   SPI_DIV   SCK half-period in clk cycles (>= 1).
//
// Ports
//   clk     in   sole clock, rising edge
//   rst     in   synchronous, active-high reset
//   scl_i   in   I2C SCL (asynchronous)
//   sda_i   in   I2C SDA (asynchronous)
//   sda_oe  out  1 = pull SDA low (open drain), 0 = release
//   sck     out  SPI clock, idles low
//   mosi    out  SPI data out, MSB first
//   miso    in   SPI data in
//   cs_n    out  SPI chip select, active low
//   busy    out  SPI byte transfer in progress
//
// Build option
//   I2C_GLITCH_FILTER_EN  when defined, a 3-sample majority-free agreement
//                         filter follows each synchronizer (+2 clk latency,
//                         pulses shorter than 3 clk are ignored).
// ---------------------------------------------------------------------------
module i2c_spi_bridge #(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int         SPI_DIV  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic sck,
  output logic mosi,
  input  logic miso,
  output logic cs_n,
  output logic busy
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WDATA    = 3'd3,
    ST_WACK     = 3'd4,
    ST_RDATA    = 3'd5,
    ST_RACK     = 3'd6,
    ST_WAIT     = 3'd7
  } state_t;

  // Input conditioning
  logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
  logic scl_f_s, sda_f_s;
  logic scl_prev_r, sda_prev_r;

  // Bus events
  logic scl_rise_s, scl_fall_s, start_s, stop_s;

  // I2C slave state
  state_t      state_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  tx_sh_r;
  logic        rw_r;
  logic        master_ack_r;
  logic        sda_oe_r;
  logic        cs_n_r;
  logic        cs_release_r;

  // SPI master state
  logic             spi_start_s;
  logic [7:0]       spi_byte_s;
  logic             busy_r;
  logic             sck_r;
  logic             mosi_r;
  logic [7:0]       spi_tx_r;
  logic [7:0]       spi_rx_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [3:0]       edge_cnt_r;
  logic [7:0]       rx_reg_r;

  // Two-flop synchronizers; idle bus level is high, so reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_i;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda_i;
      sda_sync_r <= sda_meta_r;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r, sda_hist_r;
  logic       scl_filt_r, sda_filt_r;

  // A new level is accepted only once three consecutive samples agree
  always_comb begin
    scl_f_s = scl_filt_r;
    sda_f_s = sda_filt_r;
    if ((scl_sync_r == scl_hist_r[0]) && (scl_hist_r[0] == scl_hist_r[1])) begin
      scl_f_s = scl_sync_r;
    end else begin
      scl_f_s = scl_filt_r;
    end
    if ((sda_sync_r == sda_hist_r[0]) && (sda_hist_r[0] == sda_hist_r[1])) begin
      sda_f_s = sda_sync_r;
    end else begin
      sda_f_s = sda_filt_r;
    end
  end

  // Sample history and held filter output
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r};
      scl_filt_r <= scl_f_s;
      sda_filt_r <= sda_f_s;
    end
  end
`else
  // Synchronizer output feeds edge detection directly
  always_comb begin
    scl_f_s = scl_sync_r;
    sda_f_s = sda_sync_r;
  end
`endif

  // Previous conditioned levels for edge and bus-condition detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_f_s;
      sda_prev_r <= sda_f_s;
    end
  end

  // SCL edges, START/STOP, and the decision to launch an SPI byte
  always_comb begin
    scl_rise_s  = scl_f_s & ~scl_prev_r;
    scl_fall_s  = ~scl_f_s & scl_prev_r;
    start_s     = scl_f_s & scl_prev_r & sda_prev_r & ~sda_f_s;
    stop_s      = scl_f_s & scl_prev_r & ~sda_prev_r & sda_f_s;
    spi_byte_s  = {shift_r[6:0], sda_f_s};
    spi_start_s = 1'b0;
    if ((state_r == ST_WDATA) && scl_rise_s && (bit_cnt_r == 4'd7) && !busy_r) begin
      spi_start_s = 1'b1;
    end else begin
      spi_start_s = 1'b0;
    end
  end

  // I2C slave protocol FSM; sda_oe only moves on SCL falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 8'h00;
      tx_sh_r      <= 8'h00;
      rw_r         <= 1'b0;
      master_ack_r <= 1'b0;
      sda_oe_r     <= 1'b0;
      cs_n_r       <= 1'b1;
      cs_release_r <= 1'b0;
    end else begin
      // Deferred chip-select release: wait for an in-flight byte to finish
      if (cs_release_r && !busy_r) begin
        cs_n_r       <= 1'b1;
        cs_release_r <= 1'b0;
      end

      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
      end else if (stop_s) begin
        state_r      <= ST_IDLE;
        bit_cnt_r    <= 4'd0;
        sda_oe_r     <= 1'b0;
        cs_release_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            bit_cnt_r <= 4'd0;
          end

          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r <= {shift_r[6:0], sda_f_s};
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                // shift_r[6:0] holds the seven address bits; sda is R/W
                if (shift_r[6:0] == I2C_ADDR) begin
                  state_r <= ST_ADDR_ACK;
                  rw_r    <= sda_f_s;
                end else begin
                  state_r <= ST_WAIT;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            // First fall: start ACK. Second fall: ACK bit is over.
            if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else if (rw_r) begin
                state_r   <= ST_RDATA;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= ~rx_reg_r[7];
                tx_sh_r   <= {rx_reg_r[6:0], 1'b0};
              end else begin
                state_r      <= ST_WDATA;
                bit_cnt_r    <= 4'd0;
                sda_oe_r     <= 1'b0;
                cs_n_r       <= 1'b0;
                cs_release_r <= 1'b0;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_r <= {shift_r[6:0], sda_f_s};
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                // Previous byte still shifting: refuse this one (NACK)
                if (busy_r) begin
                  state_r <= ST_WAIT;
                end else begin
                  state_r <= ST_WACK;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end

          ST_WACK: begin
            if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_WDATA;
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r  <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_RACK;
              end else begin
                sda_oe_r <= ~tx_sh_r[7];
                tx_sh_r  <= {tx_sh_r[6:0], 1'b0};
              end
            end
          end

          ST_RACK: begin
            if (scl_rise_s) begin
              master_ack_r <= ~sda_f_s;
            end else if (scl_fall_s) begin
              if (master_ack_r) begin
                state_r   <= ST_RDATA;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= ~rx_reg_r[7];
                tx_sh_r   <= {rx_reg_r[6:0], 1'b0};
              end else begin
                state_r <= ST_WAIT;
              end
            end
          end

          ST_WAIT: begin
            sda_oe_r <= 1'b0;
          end

          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Mode-0 SPI byte engine: MISO captured on SCK rise, MOSI advanced on fall
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
      spi_tx_r   <= 8'h00;
      spi_rx_r   <= 8'h00;
      div_cnt_r  <= '0;
      edge_cnt_r <= 4'd0;
      rx_reg_r   <= 8'h00;
    end else if (spi_start_s) begin
      busy_r     <= 1'b1;
      sck_r      <= 1'b0;
      spi_tx_r   <= spi_byte_s;
      mosi_r     <= spi_byte_s[7];
      div_cnt_r  <= '0;
      edge_cnt_r <= 4'd0;
    end else if (busy_r) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r  <= '0;
        edge_cnt_r <= edge_cnt_r + 4'd1;
        if (!sck_r) begin
          sck_r    <= 1'b1;
          spi_rx_r <= {spi_rx_r[6:0], miso};
        end else begin
          sck_r    <= 1'b0;
          spi_tx_r <= {spi_tx_r[6:0], 1'b0};
          mosi_r   <= spi_tx_r[6];
          // 16th half-period is the 8th fall: byte complete
          if (edge_cnt_r == 4'd15) begin
            busy_r   <= 1'b0;
            rx_reg_r <= spi_rx_r;
          end
        end
      end else begin
        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign sda_oe = sda_oe_r;
  assign sck    = sck_r;
  assign mosi   = mosi_r;
  assign cs_n   = cs_n_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_i2c_spi_bridge.sv
// ---------------------------------------------------------------------------
// tb_i2c_spi_bridge
//
// Directed-plus-random bench for i2c_spi_bridge. An I2C master is modelled by
// tasks driving SCL/SDA on the falling clk edge; an SPI slave model feeds
// MISO bytes and logs MOSI bytes. Expected values come from a simple
// transaction model: every accepted written byte must appear on MOSI, and a
// read must return the MISO byte offered during the last accepted write.
// ---------------------------------------------------------------------------
module tb_i2c_spi_bridge;

  localparam int SPI_DIV_TB = 6;

  logic clk = 1'b0;
  logic rst;
  logic scl_drv, sda_drv;
  logic sda_line;
  logic sda_oe, sck, mosi, miso, cs_n, busy;

  int checks = 0;
  int errors = 0;
  int q = 10;  // quarter SCL period in clk cycles

  // SPI-slave model and monitors (written only by the monitor process)
  logic       sck_prev = 1'b0;
  logic [2:0] mbit = 3'd0;
  logic [3:0] mosi_bits = 4'd0;
  logic [7:0] mosi_acc = 8'h00;
  logic [7:0] mosi_log [0:63];
  int         mosi_cnt = 0;
  int         sck_rises = 0;
  int         cs_low_cnt = 0;
  int         cs_high_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] miso_byte;

  always #5 clk = ~clk;

  assign sda_line = sda_drv & ~sda_oe;
  assign miso     = miso_byte[3'd7 - mbit];

  i2c_spi_bridge #(.I2C_ADDR(7'h42), .SPI_DIV(SPI_DIV_TB)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_drv),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso),
    .cs_n   (cs_n),
    .busy   (busy)
  );

  // Bus monitor and SPI slave behaviour, sampled between active edges
  always @(negedge clk) begin
    sck_prev <= sck;
    if (sck === 1'b1 && sck_prev === 1'b0) begin
      sck_rises <= sck_rises + 1;
      mosi_acc  <= {mosi_acc[6:0], mosi};
      if (mosi_bits == 4'd7) begin
        mosi_log[mosi_cnt] <= {mosi_acc[6:0], mosi};
        mosi_cnt  <= mosi_cnt + 1;
        mosi_bits <= 4'd0;
      end else begin
        mosi_bits <= mosi_bits + 4'd1;
      end
    end
    if (sck === 1'b0 && sck_prev === 1'b1) mbit <= mbit + 3'd1;
    if (cs_n === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
    if (cs_n === 1'b1) cs_high_cnt <= cs_high_cnt + 1;
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clk(q);
    scl_drv = 1'b1; wait_clk(q);
    sda_drv = 1'b0; wait_clk(q);
    scl_drv = 1'b0; wait_clk(q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clk(q);
    scl_drv = 1'b1; wait_clk(q);
    sda_drv = 1'b1; wait_clk(q);
  endtask

  task automatic send_bit(input logic b, output logic line);
    sda_drv = b;    wait_clk(q);
    scl_drv = 1'b1; wait_clk(q);
    line = sda_line; wait_clk(q);
    scl_drv = 1'b0; wait_clk(q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) send_bit(b[i], line);
    send_bit(1'b1, line);
    acked = ~line;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic line;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, line);
      b = {b[6:0], line};
    end
    send_bit(~ack, line);
  endtask

  task automatic wait_cs_release();
    for (int i = 0; i < 2000 && cs_n !== 1'b1; i++) @(negedge clk);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd, d, d2, m, exp_rx;
    int         r0, c0, h0, l0, o0;

    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; miso_byte = 8'h00;
    exp_rx = 8'h00;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_reg", dut.rx_reg_r, exp_rx);

    // Write 0xA5 while the SPI slave answers 0x3C
    miso_byte = 8'h3C; r0 = sck_rises; c0 = mosi_cnt;
    i2c_start();
    write_byte(8'h84, ack); check("a_addr_ack", ack, 1'b1);
    check("a_cs_low", cs_n, 1'b0);
    write_byte(8'hA5, ack); check("a_data_ack", ack, 1'b1);
    i2c_stop();
    wait_cs_release();
    check("a_cs_high", cs_n, 1'b1);
    check("a_mosi", mosi_log[c0], 8'hA5);
    check("a_sck_rises", sck_rises - r0, 8);
    exp_rx = 8'h3C;

    // Read back twice: master ACKs then NACKs
    i2c_start();
    write_byte(8'h85, ack); check("r_addr_ack", ack, 1'b1);
    read_byte(1'b1, rd); check("r_byte0", rd, exp_rx);
    read_byte(1'b0, rd); check("r_byte1", rd, exp_rx);
    i2c_stop(); wait_clk(q);
    check("r_sda_released", sda_oe, 1'b0);

    // Wrong address: nothing must react
    r0 = sck_rises; l0 = cs_low_cnt; o0 = oe_cnt;
    i2c_start();
    write_byte(8'h86, ack); check("m_addr_nack", ack, 1'b0);
    write_byte(8'h5A, ack); check("m_data_nack", ack, 1'b0);
    i2c_stop(); wait_clk(100);
    check("m_no_sck", sck_rises - r0, 0);
    check("m_no_cs", cs_low_cnt - l0, 0);
    check("m_no_oe", oe_cnt - o0, 0);

    // Write 0x11, repeated START, read: CS held low throughout
    m = 8'($urandom); miso_byte = m; c0 = mosi_cnt;
    i2c_start();
    write_byte(8'h84, ack); check("s_addr_ack", ack, 1'b1);
    write_byte(8'h11, ack); check("s_data_ack", ack, 1'b1);
    exp_rx = m;
    h0 = cs_high_cnt;
    i2c_start();
    write_byte(8'h85, ack); check("s_raddr_ack", ack, 1'b1);
    read_byte(1'b0, rd); check("s_read", rd, exp_rx);
    check("s_cs_held", cs_high_cnt - h0, 0);
    i2c_stop();
    wait_cs_release();
    check("s_cs_high", cs_n, 1'b1);
    check("s_mosi", mosi_log[c0], 8'h11);

    // Randomised write/read round trips
    for (int it = 0; it < 4; it++) begin
      d = 8'($urandom); m = 8'($urandom); miso_byte = m; c0 = mosi_cnt;
      i2c_start();
      write_byte(8'h84, ack); check("x_addr_ack", ack, 1'b1);
      write_byte(d, ack); check("x_data_ack", ack, 1'b1);
      i2c_stop();
      wait_cs_release();
      exp_rx = m;
      check("x_mosi", mosi_log[c0], d);
      i2c_start();
      write_byte(8'h85, ack); check("x_raddr_ack", ack, 1'b1);
      read_byte(1'b0, rd); check("x_read", rd, exp_rx);
      i2c_stop();
    end

    // Overrun: fast SCL lands a second byte while the first is still shifting
    d = 8'($urandom); d2 = 8'($urandom); m = 8'($urandom); miso_byte = m;
    c0 = mosi_cnt;
    q = 2;
    i2c_start();
    write_byte(8'h84, ack); check("o_addr_ack", ack, 1'b1);
    write_byte(d, ack); check("o_first_ack", ack, 1'b1);
    write_byte(d2, ack); check("o_second_nack", ack, 1'b0);
    i2c_stop();
    q = 10;
    wait_cs_release();
    exp_rx = m;
    check("o_cs_high", cs_n, 1'b1);
    check("o_one_byte", mosi_cnt - c0, 1);
    check("o_mosi", mosi_log[c0], d);
    i2c_start();
    write_byte(8'h85, ack); check("o_raddr_ack", ack, 1'b1);
    read_byte(1'b0, rd); check("o_read", rd, exp_rx);
    i2c_stop(); wait_clk(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
